// File: rtl/lcd_write_engine.sv
// HD44780-style write engine: strobes one byte onto the panel pins, waits out execution, pulses wr_finish.
// Define LCD_4BIT_EN to send each byte as two nibble strobes on lcd_db[7:4].
module lcd_write_engine #(
  parameter int SETUP_CYC     = 1,
  parameter int E_HIGH_CYC    = 1,
  parameter int HOLD_CYC      = 1,
  parameter int EXEC_CYC      = 1,
  parameter int EXEC_LONG_CYC = 2
) (
  input  logic       clk_1ms,
  input  logic       reset_n,
  input  logic       wr_enable,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       wr_finish,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, EXEC, DONE} state_t;

  // Counter reload value: a zero-length phase still lasts one cycle.
  function automatic logic [7:0] cyc_load(input int n);
    int m;
    m = (n < 1) ? 1 : n;
    return 8'(m - 1);
  endfunction

  localparam logic [7:0] SETUP_LD = cyc_load(SETUP_CYC);
  localparam logic [7:0] EHIGH_LD = cyc_load(E_HIGH_CYC);
  localparam logic [7:0] HOLD_LD  = cyc_load(HOLD_CYC);
  localparam logic [7:0] EXEC_LD  = cyc_load(EXEC_CYC);
  localparam logic [7:0] LONG_LD  = cyc_load(EXEC_LONG_CYC);

  state_t     state;
  logic [7:0] cnt;
  logic       rs_lat;
  logic [7:0] data_lat;
  logic       long_cmd;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd = !rs_lat && (data_lat[7:2] == 6'd0) && (data_lat[1:0] != 2'd0);
  assign lcd_rw   = 1'b0;

`ifdef LCD_4BIT_EN
  logic second;
`endif

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      rs_lat    <= 1'b0;
      data_lat  <= 8'h00;
      wr_finish <= 1'b0;
      busy      <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
`ifdef LCD_4BIT_EN
      second    <= 1'b0;
`endif
    end else begin
      wr_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_enable) begin
            rs_lat   <= rs_in;
            data_lat <= data_in;
            lcd_rs   <= rs_in;
            busy     <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
`ifdef LCD_4BIT_EN
            lcd_db   <= {data_in[7:4], 4'h0};
            second   <= 1'b0;
`else
            lcd_db   <= data_in;
`endif
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            lcd_e <= 1'b1;
            cnt   <= EHIGH_LD;
            state <= EHIGH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        EHIGH: begin
          if (cnt == 8'd0) begin
            lcd_e <= 1'b0;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
`ifdef LCD_4BIT_EN
          end else if (!second) begin
            second <= 1'b1;
            lcd_db <= {data_lat[3:0], 4'h0};
            cnt    <= SETUP_LD;
            state  <= SETUP;
`endif
          end else begin
            cnt   <= long_cmd ? LONG_LD : EXEC_LD;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 8'd0) begin
            wr_finish <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: table of single writes on a default and a stretched-timing instance,
// plus back-to-back requests and reset during a strobe.
module tb_lcd_write_engine;

`ifdef LCD_4BIT_EN
  localparam int NSTROBE = 2;
  localparam int F0 = 8;
  localparam int F1 = 17;
  localparam logic [31:0] EM0 = 32'h24;
  localparam logic [31:0] EM1 = 32'h71C;
  localparam int PERIOD = 9;
`else
  localparam int NSTROBE = 1;
  localparam int F0 = 5;
  localparam int F1 = 11;
  localparam logic [31:0] EM0 = 32'h4;
  localparam logic [31:0] EM1 = 32'h1C;
  localparam int PERIOD = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       we0, rs0, we1, rs1;
  logic [7:0] d0, d1;
  logic       fin0, busy0, e0, lrs0, rw0;
  logic       fin1, busy1, e1, lrs1, rw1;
  logic [7:0] db0, db1;

  lcd_write_engine dut0 (
    .clk_1ms(clk), .reset_n(reset_n), .wr_enable(we0), .rs_in(rs0), .data_in(d0),
    .wr_finish(fin0), .busy(busy0), .lcd_e(e0), .lcd_rs(lrs0), .lcd_rw(rw0), .lcd_db(db0)
  );

  lcd_write_engine #(
    .SETUP_CYC(0), .E_HIGH_CYC(3), .HOLD_CYC(2), .EXEC_CYC(4)
  ) dut1 (
    .clk_1ms(clk), .reset_n(reset_n), .wr_enable(we1), .rs_in(rs1), .data_in(d1),
    .wr_finish(fin1), .busy(busy1), .lcd_e(e1), .lcd_rs(lrs1), .lcd_rw(rw1), .lcd_db(db1)
  );

  logic       sel = 1'b0;
  logic       s_e, s_fin, s_busy, s_rs, s_rw;
  logic [7:0] s_db;
  assign s_e    = sel ? e1    : e0;
  assign s_fin  = sel ? fin1  : fin0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_rs   = sel ? lrs1  : lrs0;
  assign s_rw   = sel ? rw1   : rw0;
  assign s_db   = sel ? db1   : db0;

  typedef struct {
    logic        rs;
    logic [7:0]  data;
    int          fin;
    int          slen;
    logic [31:0] emask;
    logic        which;
  } vec_t;

  vec_t vecs[10];
  int   exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_db(input vec_t v, input int c);
`ifdef LCD_4BIT_EN
    if (c <= v.slen) return {v.data[7:4], 4'h0};
    return {v.data[3:0], 4'h0};
`else
    if (c < 0) return 8'h00;
    return v.data;
`endif
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int got;
    sel = v.which;
    @(negedge clk);
    if (v.which) begin we1 = 1'b1; rs1 = v.rs; d1 = v.data; end
    else         begin we0 = 1'b1; rs0 = v.rs; d0 = v.data; end
    exp_q.push_back(v.fin);
    for (int c = 1; c <= v.fin + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin we0 = 1'b0; we1 = 1'b0; end
      chk($sformatf("v%0d c%0d lcd_e", idx, c), 32'(s_e), 32'(v.emask[c]));
      chk($sformatf("v%0d c%0d busy", idx, c), 32'(s_busy), (c <= v.fin) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d c%0d lcd_rw", idx, c), 32'(s_rw), 32'd0);
      chk($sformatf("v%0d c%0d lcd_db", idx, c), 32'(s_db), 32'(exp_db(v, c)));
      if (c <= NSTROBE * v.slen)
        chk($sformatf("v%0d c%0d lcd_rs", idx, c), 32'(s_rs), 32'(v.rs));
      if (s_fin) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d extra wr_finish cycle", idx), 32'(c), 32'hFFFFFFFF);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("v%0d wr_finish cycle", idx), 32'(c), 32'(got));
        end
      end
    end
    chk($sformatf("v%0d pending finishes", idx), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    $display("vec %0d which=%0d rs=%0d data=%02h fin_cycle=%0d", idx, v.which, v.rs, v.data, v.fin);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " e0"}, 32'(e0), 32'd0);
    chk({tag, " busy0"}, 32'(busy0), 32'd0);
    chk({tag, " fin0"}, 32'(fin0), 32'd0);
    chk({tag, " rs0"}, 32'(lrs0), 32'd0);
    chk({tag, " rw0"}, 32'(rw0), 32'd0);
    chk({tag, " db0"}, 32'(db0), 32'd0);
    chk({tag, " e1"}, 32'(e1), 32'd0);
    chk({tag, " busy1"}, 32'(busy1), 32'd0);
    chk({tag, " db1"}, 32'(db1), 32'd0);
  endtask

  initial begin
    int nfin;
    reset_n = 1'b0;
    we0 = 1'b0; rs0 = 1'b0; d0 = 8'h00;
    we1 = 1'b0; rs1 = 1'b0; d1 = 8'h00;

    vecs[0] = '{1'b1, 8'h41, F0,     3, EM0, 1'b0};
    vecs[1] = '{1'b0, 8'h01, F0 + 1, 3, EM0, 1'b0};
    vecs[2] = '{1'b0, 8'h38, F0,     3, EM0, 1'b0};
    vecs[3] = '{1'b0, 8'h02, F0 + 1, 3, EM0, 1'b0};
    vecs[4] = '{1'b0, 8'h03, F0 + 1, 3, EM0, 1'b0};
    vecs[5] = '{1'b0, 8'h04, F0,     3, EM0, 1'b0};
    vecs[6] = '{1'b1, 8'h01, F0,     3, EM0, 1'b0};
    vecs[7] = '{1'b1, 8'hA5, F0,     3, EM0, 1'b0};
    vecs[8] = '{1'b0, 8'h30, F1,     6, EM1, 1'b1};
    vecs[9] = '{1'b0, 8'h01, F1 - 2, 6, EM1, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    $display("reset state checked");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // wr_enable held high: only the first IDLE cycle after DONE accepts
    sel = 1'b0;
    @(negedge clk);
    we0 = 1'b1; rs0 = 1'b1; d0 = 8'h55;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("cont c%0d wr_finish", c), 32'(fin0), (c % PERIOD == PERIOD - 1) ? 32'd1 : 32'd0);
      chk($sformatf("cont c%0d busy", c), 32'(busy0), (c % PERIOD != 0) ? 32'd1 : 32'd0);
    end
    we0 = 1'b0;
    for (int i = 0; i < 30 && busy0; i++) @(negedge clk);
    chk("cont drain busy", 32'(busy0), 32'd0);
    $display("continuous request sequence done");

    // reset while E is high
    @(negedge clk);
    we0 = 1'b1; rs0 = 1'b1; d0 = 8'h41;
    @(negedge clk);
    we0 = 1'b0;
    @(negedge clk);
    chk("midreset e before", 32'(e0), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    nfin = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fin0) nfin++;
    end
    chk("midreset no wr_finish", 32'(nfin), 32'd0);
    chk("midreset idle busy", 32'(busy0), 32'd0);
    $display("reset mid-write sequence done");

    run_vec(vecs[0], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
